// File: rtl/morty_mem_arbiter.sv
// Shares one Wishbone-classic master between instruction fetch and load/store.
// Optional bus timeout is enabled with `define MORTY_BUS_TIMEOUT_EN.
module morty_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_valid_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic [31:0] ls_rdata_o,
  output logic        ls_valid_o,
  output logic        is_IF_o,
  output logic        is_MEM_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q;            // 1 = LS, 0 = IF
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;

  logic        grant;
  logic        ls_misalign;
  logic        if_misalign;
  logic        req_bad;
  logic [31:0] st_dat;
  logic [3:0]  st_sel;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic        tmo_hit;
  logic        bus_done;

  assign grant       = ls_req_i | if_req_i;
  assign ls_misalign = (ls_size_i == 2'b11) ||
                       (ls_size_i == 2'b01 && ls_addr_i[0]) ||
                       (ls_size_i == 2'b10 && ls_addr_i[1:0] != 2'b00);
  assign if_misalign = (if_addr_i[1:0] != 2'b00);
  assign req_bad     = ls_req_i ? ls_misalign : if_misalign;

  // Replicate store data onto every lane; sel picks the lane the slave writes.
  always_comb begin
    st_dat = ls_wdata_i;
    st_sel = 4'b1111;
    case (ls_size_i)
      2'b00: begin
        st_dat = {4{ls_wdata_i[7:0]}};
        st_sel = 4'b0001 << ls_addr_i[1:0];
      end
      2'b01: begin
        st_dat = {2{ls_wdata_i[15:0]}};
        st_sel = ls_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_dat = ls_wdata_i;
        st_sel = 4'b1111;
      end
    endcase
  end

  assign shifted = wb_dat_i >> {off_q, 3'b000};

  always_comb begin
    load_val = wb_dat_i;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = wb_dat_i;
    endcase
  end

`ifdef MORTY_BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  assign tmo_hit = (state_q == BUS) && !wb_ack_i && !wb_err_i && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == IDLE) begin
      tmo_cnt_q <= 8'd0;
    end else if (state_q == BUS && !wb_ack_i && !wb_err_i) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign bus_done = wb_ack_i | wb_err_i | tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = req_bad ? DONE : BUS;
      BUS:     if (bus_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      off_q      <= 2'd0;
      err_q      <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else if (state_q == IDLE && grant) begin
      owner_q <= ls_req_i;
      err_q   <= req_bad;
      if (ls_req_i) begin
        we_q   <= ls_we_i;
        adr_q  <= {ls_addr_i[31:2], 2'b00};
        dat_q  <= ls_we_i ? st_dat : 32'd0;
        sel_q  <= ls_we_i ? st_sel : 4'b1111;
        size_q <= ls_size_i;
        uns_q  <= ls_unsigned_i;
        off_q  <= ls_addr_i[1:0];
        if (req_bad) ls_rdata_q <= 32'd0;
      end else begin
        we_q   <= 1'b0;
        adr_q  <= {if_addr_i[31:2], 2'b00};
        dat_q  <= 32'd0;
        sel_q  <= 4'b1111;
        size_q <= 2'b10;
        uns_q  <= 1'b0;
        off_q  <= 2'b00;
        if (req_bad) if_data_q <= 32'd0;
      end
    end else if (state_q == BUS && bus_done) begin
      // Error and timeout both terminate without data.
      err_q <= wb_err_i | tmo_hit;
      if (owner_q) begin
        ls_rdata_q <= (wb_err_i | tmo_hit) ? 32'd0 : load_val;
      end else begin
        if_data_q  <= (wb_err_i | tmo_hit) ? 32'd0 : wb_dat_i;
      end
    end
  end

  assign wb_cyc_o    = (state_q == BUS);
  assign wb_stb_o    = (state_q == BUS);
  assign wb_we_o     = (state_q == BUS) & we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

  assign if_valid_o  = (state_q == DONE) & ~owner_q;
  assign ls_valid_o  = (state_q == DONE) & owner_q;
  assign bus_err_o   = (state_q == DONE) & err_q;
  assign if_data_o   = if_data_q;
  assign ls_rdata_o  = ls_rdata_q;

  // Busy flags fall in the valid cycle so the pipeline can advance.
  assign is_IF_o     = if_req_i & ~if_valid_o;
  assign is_MEM_o    = ls_req_i & ~ls_valid_o;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_morty_mem_arbiter.sv
// Directed bench for morty_mem_arbiter: table of single accesses plus
// hand-written sequences for priority, dropped requests, timeout and reset.
module tb_morty_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        is_if;
  logic        is_mem;
  logic        bus_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;
  logic [1:0]  dbg_state;

  logic        ack_en;
  logic        err_en;
  logic [31:0] slave_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Slave model: terminates combinationally while cyc/stb are up.
  assign wb_ack   = wb_cyc & wb_stb & ack_en;
  assign wb_err   = wb_cyc & wb_stb & err_en;
  assign wb_dat_r = slave_rdata;

  always #5 clk = ~clk;

  morty_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_valid_o(if_valid),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size), .ls_unsigned_i(ls_unsigned),
    .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata), .ls_rdata_o(ls_rdata), .ls_valid_o(ls_valid),
    .is_IF_o(is_if), .is_MEM_o(is_mem), .bus_err_o(bus_err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_w), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_r),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic        is_fetch;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        use_err;
    logic        on_bus;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'd0; ls_wdata = 32'd0;
    ack_en = 1'b1; err_en = 1'b0; slave_rdata = 32'd0;
  endtask

  // Starts right after a posedge with the FSM in IDLE; leaves it the same way.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    ack_en = ~v.use_err; err_en = v.use_err; slave_rdata = v.rd;
    if (v.is_fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_unsigned = v.uns;
      ls_addr = v.addr; ls_wdata = v.wdata;
    end
    @(negedge clk);
    chk({tag, " busy c0"}, {31'd0, v.is_fetch ? is_if : is_mem}, 32'd1);
    chk({tag, " cyc c0"}, {31'd0, wb_cyc}, 32'd0);
    if (v.on_bus) begin
      @(negedge clk);
      chk({tag, " cyc/stb"}, {30'd0, wb_cyc, wb_stb}, 32'd3);
      chk({tag, " adr"}, wb_adr, v.exp_adr);
      chk({tag, " sel"}, {28'd0, wb_sel}, {28'd0, v.exp_sel});
      chk({tag, " we"}, {31'd0, wb_we}, {31'd0, v.we});
      if (v.we) chk({tag, " dat"}, wb_dat_w, v.exp_dat);
      chk({tag, " valid early"}, {30'd0, if_valid, ls_valid}, 32'd0);
    end
    @(negedge clk);
    chk({tag, " cyc done"}, {31'd0, wb_cyc}, 32'd0);
    chk({tag, " valid"}, {30'd0, if_valid, ls_valid}, v.is_fetch ? 32'd2 : 32'd1);
    chk({tag, " err"}, {31'd0, bus_err}, {31'd0, v.exp_err});
    chk({tag, " busy done"}, {31'd0, v.is_fetch ? is_if : is_mem}, 32'd0);
    if (v.chk_data) chk({tag, " data"}, v.is_fetch ? if_data : ls_rdata, v.exp_data);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    //         fetch we  size   uns addr        wdata         rd            err bus exp_adr     sel    exp_dat       chkd exp_data      eerr
    vecs[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'h00500093, 1'b0, 1'b1, 32'h100, 4'hF, 32'h0,        1'b1, 32'h00500093, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h200, 4'hF, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h200, 4'hF, 32'h0,        1'b1, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'hFFFFBEEF, 32'h0,        1'b0, 1'b1, 32'h104, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h202, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h301, 32'h123456A5, 32'h0,        1'b0, 1'b1, 32'h300, 4'h2, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h402, 32'h0,        32'h80017FFF, 1'b0, 1'b1, 32'h400, 4'hF, 32'h0,        1'b1, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'h400, 32'h0,        32'h1234F00D, 1'b0, 1'b1, 32'h400, 4'hF, 32'h0,        1'b1, 32'h0000F00D, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 32'h500, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 1'b0, 32'h600, 32'h0,        32'h11111111, 1'b1, 1'b1, 32'h600, 4'hF, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'b11, 1'b0, 32'h700, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h105, 32'hBEEF,     32'h0,        1'b0, 1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h201, 32'h0,        32'h80FF1234, 1'b0, 1'b1, 32'h200, 4'hF, 32'h0,        1'b1, 32'h00000012, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h303, 32'h0000007E, 32'h0,        1'b0, 1'b1, 32'h300, 4'h8, 32'h7E7E7E7E, 1'b0, 32'h0,        1'b0};

    // Clock/reset
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst cyc/stb/we", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    chk("rst valids/err", {29'd0, if_valid, ls_valid, bus_err}, 32'd0);
    chk("rst if_data", if_data, 32'd0);
    chk("rst ls_rdata", ls_rdata, 32'd0);
    chk("rst adr", wb_adr, 32'd0);
    chk("rst state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Simultaneous requests: LS wins, IF follows at the next IDLE.
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
    slave_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("pri busy c0", {30'd0, is_mem, is_if}, 32'd3);
    @(negedge clk);
    chk("pri ls adr", wb_adr, 32'h200);
    @(negedge clk);
    chk("pri ls valid", {30'd0, if_valid, ls_valid}, 32'd1);
    chk("pri busy c2", {30'd0, is_mem, is_if}, 32'd1);
    chk("pri ls data", ls_rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    ls_req = 1'b0; slave_rdata = 32'h00500093;
    @(negedge clk);
    chk("pri c3 idle", {29'd0, wb_cyc, if_valid, ls_valid}, 32'd0);
    @(negedge clk);
    chk("pri if cyc", {31'd0, wb_cyc}, 32'd1);
    chk("pri if adr", wb_adr, 32'h100);
    @(negedge clk);
    chk("pri if valid", {30'd0, if_valid, ls_valid}, 32'd2);
    chk("pri if busy", {31'd0, is_if}, 32'd0);
    chk("pri if data", if_data, 32'h00500093);
    @(posedge clk); #1;
    idle_inputs();

    // Requester drops its request while the slave is stalling.
    ack_en = 1'b0;
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'h800;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(negedge clk);
    chk("drop cyc w1", {31'd0, wb_cyc}, 32'd1);
    @(posedge clk); #1;
    ack_en = 1'b1; slave_rdata = 32'h12345678;
    @(negedge clk);
    chk("drop cyc w2", {31'd0, wb_cyc}, 32'd1);
    @(negedge clk);
    chk("drop valid", {30'd0, if_valid, ls_valid}, 32'd1);
    chk("drop data", ls_rdata, 32'h12345678);
    chk("drop busy", {31'd0, is_mem}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();

`ifdef MORTY_BUS_TIMEOUT_EN
    // Silent slave with a 4-cycle limit.
    ack_en = 1'b0;
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'hB00;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("tmo cyc w%0d", i), {30'd0, wb_cyc, ls_valid}, 32'd2);
    end
    @(negedge clk);
    chk("tmo cyc drop", {31'd0, wb_cyc}, 32'd0);
    chk("tmo valid/err", {30'd0, ls_valid, bus_err}, 32'd3);
    chk("tmo data", ls_rdata, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
`endif

    // Reset asserted mid-cycle while waiting on a silent slave.
    ack_en = 1'b0;
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'hA00;
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst wait cyc w%0d", i), {31'd0, wb_cyc}, 32'd1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst mid cyc/stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    chk("rst mid valids", {29'd0, if_valid, ls_valid, bus_err}, 32'd0);
    ls_req = 1'b0;
    @(negedge clk);
    chk("rst held valids", {29'd0, if_valid, ls_valid, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post rst state", {30'd0, dbg_state}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
